// File: rtl/xpb_reduce_acc_if.sv
// Handshake and xpb table-bank bus for the reduction accumulator.
// The slave side is the accumulator; the master side is the producer, consumer and table bank.
interface xpb_reduce_acc_if #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned DIGIT_W    = 5,
    parameter int unsigned GUARD_W    = 4,
    parameter int unsigned IDX_W      = 3
);
    logic                            start;
    logic                            in_ready;
    logic [1023:0]                   low_in;
    logic [NUM_DIGITS*DIGIT_W-1:0]   high_in;
    logic [IDX_W-1:0]                lut_idx;
    logic [DIGIT_W-1:0]              lut_digit;
    logic [1023:0]                   lut_value;
    logic                            out_valid;
    logic                            out_ready;
    logic [1024+GUARD_W-1:0]         result;

    modport master (
        output start, low_in, high_in, lut_value, out_ready,
        input  in_ready, lut_idx, lut_digit, out_valid, result
    );

    modport slave (
        input  start, low_in, high_in, lut_value, out_ready,
        output in_ready, lut_idx, lut_digit, out_valid, result
    );
endinterface

// File: rtl/xpb_reduce_acc.sv
// Sequential xpb reduction: walks the upper digits one per cycle and sums the
// table bank's answers onto the low 1024 bits, then holds the result for a valid/ready consumer.
module xpb_reduce_acc #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned DIGIT_W    = 5,
    parameter int unsigned GUARD_W    = 4,
    parameter int unsigned IDX_W      = 3
) (
    input  logic             clk,
    input  logic             reset,
    xpb_reduce_acc_if.slave  bus
);
    localparam int unsigned       ACC_W    = 1024 + GUARD_W;
    localparam int unsigned       HIGH_W   = NUM_DIGITS * DIGIT_W;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [HIGH_W-1:0]   shreg_q, shreg_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d;

    logic                in_ready_c;
    logic                out_valid_c;
    logic [IDX_W-1:0]    lut_idx_c;
    logic [DIGIT_W-1:0]  lut_digit_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        lut_idx_c   = '0;
        lut_digit_c = '0;
        unique case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.start) begin
                    acc_d   = {{GUARD_W{1'b0}}, bus.low_in};
                    shreg_d = bus.high_in;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                // Digit 0 always sits at the bottom of shreg; cnt names its table.
                lut_idx_c   = cnt_q;
                lut_digit_c = shreg_q[DIGIT_W-1:0];
                acc_d       = acc_q + {{GUARD_W{1'b0}}, bus.lut_value};
                shreg_d     = shreg_q >> DIGIT_W;
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.lut_idx   = lut_idx_c;
    assign bus.lut_digit = lut_digit_c;
    assign bus.result    = acc_q;
endmodule

// File: tb/tb_xpb_reduce_acc.sv
// Self-checking bench for xpb_reduce_acc: timeline reference model checked every
// cycle, plus directed literal expectations for the key scenarios.
module tb_xpb_reduce_acc;
    localparam int N  = 8;
    localparam int DW = 5;
    localparam int GW = 4;
    localparam int IW = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    xpb_reduce_acc_if #(.NUM_DIGITS(N), .DIGIT_W(DW), .GUARD_W(GW), .IDX_W(IW)) bus();

    xpb_reduce_acc #(.NUM_DIGITS(N), .DIGIT_W(DW), .GUARD_W(GW), .IDX_W(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int failures = 0;
    int lut_mode = 0;
    bit chk_en = 1'b0;
    logic [1023:0] lut_tab [0:N-1][0:31];

    // Table bank: 0 = zeros, 1 = digit << 32*idx, 2 = all ones, 3 = random table
    assign bus.lut_value = (lut_mode == 0) ? 1024'b0 :
                           (lut_mode == 1) ? ({1019'b0, bus.lut_digit} << (32 * bus.lut_idx)) :
                           (lut_mode == 2) ? {1024{1'b1}} :
                           lut_tab[bus.lut_idx][bus.lut_digit];

    task automatic check(input string name, input logic [1027:0] act, input logic [1027:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [1023:0] lut_fn(input int mode, input int idx, input int dig);
        logic [1023:0] v;
        case (mode)
            0: v = '0;
            1: v = 1024'(dig) << (32 * idx);
            2: v = '1;
            default: v = lut_tab[idx][dig];
        endcase
        return v;
    endfunction

    function automatic logic [1027:0] model_sum(input logic [1023:0] low, input logic [N*DW-1:0] high);
        logic [1027:0] s;
        s = {4'b0, low};
        for (int k = 0; k < N; k++) begin
            s = s + {4'b0, lut_fn(lut_mode, k, int'(high[k*DW +: DW]))};
        end
        return s;
    endfunction

    // Reference timeline: idle, or m_k cycles past accept (m_k == N means result held)
    bit            m_idle = 1'b1;
    int            m_k = 0;
    bit            m_res_zero = 1'b1;
    int            m_digit [0:N-1];
    logic [1027:0] m_sum = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_idle = 1'b1;
            m_k = 0;
            m_res_zero = 1'b1;
        end else if (m_idle) begin
            if (bus.start) begin
                m_idle = 1'b0;
                m_k = 0;
                m_res_zero = 1'b0;
                for (int k = 0; k < N; k++) m_digit[k] = int'(bus.high_in[k*DW +: DW]);
                m_sum = model_sum(bus.low_in, bus.high_in);
            end
        end else if (m_k < N) begin
            m_k++;
        end else if (bus.out_ready) begin
            m_idle = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit exp_valid;
            bit exp_accum;
            exp_valid = !m_idle && (m_k == N);
            exp_accum = !m_idle && (m_k < N);
            check("in_ready", 1028'(bus.in_ready), 1028'(m_idle));
            check("out_valid", 1028'(bus.out_valid), 1028'(exp_valid));
            check("lut_idx", 1028'(bus.lut_idx), exp_accum ? 1028'(m_k) : 1028'(0));
            check("lut_digit", 1028'(bus.lut_digit), exp_accum ? 1028'(m_digit[m_k]) : 1028'(0));
            if (exp_valid) check("result", bus.result, m_sum);
            else if (m_idle && m_res_zero) check("result_zero", bus.result, '0);
        end
    end

    int seen_idx [0:N-1];
    int seen_digit [0:N-1];

    // Entered and left #1 after a rising edge.
    task automatic run_op(input logic [1023:0] low, input logic [N*DW-1:0] high, input int bp,
                          output int lat, output logic [1027:0] res);
        bus.low_in = low;
        bus.high_in = high;
        bus.start = 1'b1;
        bus.out_ready = (bp == 0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            if (lat < N) begin
                seen_idx[lat] = int'(bus.lut_idx);
                seen_digit[lat] = int'(bus.lut_digit);
            end
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.out_valid) check("op_timeout", 1028'(bus.out_valid), 1028'(1));
        res = bus.result;
        repeat (bp) begin @(posedge clk); #1; end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    function automatic logic [1023:0] rand_1024();
        logic [1023:0] v;
        for (int w = 0; w < 32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [N*DW-1:0] rand_high();
        logic [63:0] v;
        v = {$urandom, $urandom};
        return v[N*DW-1:0];
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [1027:0] res;
        logic [1023:0] low;
        logic [N*DW-1:0] high;
        int exp_d [0:N-1];
        exp_d = '{3, 2, 0, 0, 0, 0, 0, 31};

        bus.start = 1'b0;
        bus.low_in = '0;
        bus.high_in = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < N; i++)
            for (int d = 0; d < 32; d++) lut_tab[i][d] = rand_1024();

        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_in_ready", 1028'(bus.in_ready), 1028'(1));
        check("rst_out_valid", 1028'(bus.out_valid), 1028'(0));
        check("rst_result", bus.result, '0);
        check("rst_lut_idx", 1028'(bus.lut_idx), 1028'(0));
        @(posedge clk); #1;

        // Pass-through
        lut_mode = 0;
        run_op(1024'h1234, '0, 0, lat, res);
        check("pass_latency", 1028'(lat), 1028'(8));
        check("pass_result", res, 1028'h1234);
        for (int i = 0; i < N; i++) begin
            check("pass_idx_step", 1028'(seen_idx[i]), 1028'(i));
            check("pass_digit_zero", 1028'(seen_digit[i]), 1028'(0));
        end

        // Digit ordering
        lut_mode = 1;
        high = {5'h1F, 25'h0, 5'h2, 5'h3};
        run_op('0, high, 1, lat, res);
        check("order_result", res, 1028'h3 + (1028'h2 << 32) + (1028'h1F << 224));
        for (int i = 0; i < N; i++) check("order_digit", 1028'(seen_digit[i]), 1028'(exp_d[i]));

        // Maximum sum
        lut_mode = 2;
        run_op('1, '1, 0, lat, res);
        check("max_result", res, (1028'd1 << 1027) + (1028'd1 << 1024) - 1028'd9);

        // Backpressure with ignored starts
        lut_mode = 3;
        low = rand_1024();
        high = rand_high();
        bus.low_in = low;
        bus.high_in = high;
        bus.out_ready = 1'b0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        bus.start = 1'b1;
        bus.low_in = '0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        check("bp_valid_seen", 1028'(bus.out_valid), 1028'(1));
        for (int c = 0; c < 5; c++) begin
            bus.start = (c == 1);
            check("bp_in_ready_low", 1028'(bus.in_ready), 1028'(0));
            check("bp_valid_held", 1028'(bus.out_valid), 1028'(1));
            check("bp_result_held", bus.result, model_sum(low, high));
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_idle_return", 1028'(bus.in_ready), 1028'(1));
        check("bp_valid_drop", 1028'(bus.out_valid), 1028'(0));
        repeat (3) begin @(posedge clk); #1; end
        check("bp_no_second_op", 1028'(bus.in_ready), 1028'(1));

        // Reset mid-operation at cnt=4
        bus.low_in = rand_1024();
        bus.high_in = rand_high();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        check("abort_at_cnt4", 1028'(bus.lut_idx), 1028'(4));
        reset = 1'b1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.start = 1'b0;
        check("abort_in_ready", 1028'(bus.in_ready), 1028'(1));
        check("abort_out_valid", 1028'(bus.out_valid), 1028'(0));
        check("abort_result", bus.result, '0);
        repeat (12) begin @(posedge clk); #1; end
        check("abort_no_valid", 1028'(bus.out_valid), 1028'(0));
        low = rand_1024();
        high = rand_high();
        run_op(low, high, 0, lat, res);
        check("fresh_latency", 1028'(lat), 1028'(8));
        check("fresh_result", res, model_sum(low, high));

        // Randomised operations with random backpressure and gaps
        for (int n = 0; n < 25; n++) begin
            low = ($urandom_range(0, 3) == 0) ? '1 : rand_1024();
            high = rand_high();
            run_op(low, high, int'($urandom_range(0, 3)), lat, res);
            check("rand_result", res, model_sum(low, high));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/xpb_reduce_acc.md
# xpb_reduce_acc

Sequential reduction accumulator that consumes the 1024-bit values produced by the per-position xpb lookup tables in the modular-squaring datapath. It takes the low 1024 bits of a squared operand and the upper bits as NUM_DIGITS 5-bit digits. It then walks the digits one per cycle, drives each digit and its position index to the external xpb table bank, and sums the returned values onto the low part. The result is a partially reduced value, 1024 + GUARD_W bits wide, handed downstream with a valid/ready handshake.

## Interface
- NUM_DIGITS, 8, number of 5-bit upper digits per operation (≥1).
- DIGIT_W, 5, digit width; it matches the xpb table select width.
- GUARD_W, 4, extra accumulator bits above 1024. Required: NUM_DIGITS+1 ≤ 2^GUARD_W.
- IDX_W, 3, width of lut_idx. Required: 2^IDX_W ≥ NUM_DIGITS.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to begin an operation; accepted only when in_ready=1.
- in_ready  out  1  high only in IDLE.
- low_in  in  1024  low part of the square; sampled on accept.
- high_in  in  NUM_DIGITS*DIGIT_W  upper digits; digit 0 = bits [DIGIT_W-1:0]. Sampled on accept.
- lut_idx  out  IDX_W  position of the current digit; selects which xpb table answers.
- lut_digit  out  DIGIT_W  current digit, driven to the selected xpb table.
- lut_value  in  1024  table output for (lut_idx, lut_digit); combinational, same cycle.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- result  out  1024+GUARD_W  accumulated sum.

## Operation
- FSM has three states: IDLE, ACCUM, DONE. Reset enters IDLE.
- **IDLE**
  - in_ready=1.
  - On start=1: acc ← zero-extended low_in, shreg ← high_in, cnt ← 0, state → ACCUM.
  - With start=0, state is unchanged.
- **ACCUM**
  - lut_idx = cnt; lut_digit = shreg[DIGIT_W-1:0].
  - Each edge: acc ← acc + zero-extended lut_value; shreg ← shreg >> DIGIT_W; cnt ← cnt+1.
  - On the edge where cnt = NUM_DIGITS-1 (after its add), state → DONE.
  - Zero digits are not skipped. The latency is constant.
- **DONE**
  - out_valid=1; result = acc, held stable.
  - On out_valid & out_ready: state → IDLE.
- Arithmetic:
  - Unsigned addition, modulo 2^(1024+GUARD_W).
  - The parameter constraint guarantees that no overflow occurs when every lut_value < 2^1024.
- Outputs outside their active state:
  - lut_idx=0, lut_digit=0 outside ACCUM.
  - result holds acc in DONE; it is don't-care elsewhere but must not be X after reset.
- start while not IDLE is ignored. There is no queueing; the request is not remembered.
- No back-to-back overlap: a new operation can be accepted only after the DONE→IDLE edge.

## Timing
- Reset values (apply on the next edge while reset=1, regardless of state):
  - state=IDLE, in_ready=1, out_valid=0.
  - acc=0, result=0, cnt=0, shreg=0, lut_idx=0, lut_digit=0.
- Accept edge E0 is the edge where start=1 and in_ready=1. in_ready is 0 from E0 onward.
- ACCUM occupies the cycles between E0 and E_NUM_DIGITS. Digit k is presented in the cycle after edge E_k.
- out_valid rises after edge E_NUM_DIGITS: NUM_DIGITS cycles of latency from accept.
- With out_ready held high, out_valid stays high for exactly 1 cycle, then in_ready=1.
  - Minimum issue interval is NUM_DIGITS+2 cycles.
- Backpressure: with out_ready=0, the block stays in DONE indefinitely. result and out_valid are stable, and in_ready=0.
- Reset asserted in ACCUM or DONE aborts the operation. Partial sums are discarded and no out_valid pulse is produced.
- start and reset high together: reset wins.

## Test plan
- **Pass-through:** NUM_DIGITS=8, low_in=0x1234, high_in=0, bench LUT returns 0 for digit 0.
  - Expect out_valid exactly 8 cycles after accept.
  - Expect result=0x1234.
  - Expect lut_idx stepping 0..7 with lut_digit=0 throughout.
- **Digit ordering:** high_in = digits {7:1F, 6:0, …, 1:2, 0:3}, bench LUT returns lut_digit << (32*lut_idx), low_in=0.
  - Expect result = 0x3 + (0x2<<32) + (0x1F<<224).
  - Expect the lut_digit sequence 3, 2, 0, 0, 0, 0, 0, 1F.
- **Maximum sum:** all digits 0x1F, LUT returns 2^1024-1, low_in=2^1024-1.
  - Expect result = 9·(2^1024-1), exact within 1028 bits, with no wrap.
- **Backpressure and ignored start:** out_ready=0 for 5 cycles after out_valid, with start pulsed during ACCUM and during DONE.
  - Expect result held stable and in_ready=0 throughout.
  - Expect no second operation.
  - Expect an IDLE return one cycle after out_ready=1.
- **Reset mid-operation:** assert reset at cnt=4.
  - Expect state=IDLE, out_valid=0, result=0 the next cycle.
  - A fresh start then completes normally, with a result independent of the aborted operation.
